// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle fetch/decode/execute sequencer with req/ack
//               instruction and data memory handshakes, one-cycle ALU-latch
//               and register-write strobes, and a per-access watchdog that
//               traps to a sticky error state.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int                D        = 32,
  parameter int                PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int                TIMEOUT  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [D-1:0]    imem_rdata,
  output logic [PC_W-1:0] pc,
  output logic [D-1:0]    ir,
  output logic            alu_latch,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic            retired,
  output logic            busy,
  output logic            error
);

  localparam int            CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]    c_OP_LOAD  = 4'b0100;
  localparam logic [3:0]    c_OP_STORE = 4'b0110;
  localparam logic [3:0]    c_OP_NOP   = 4'b1111;
  localparam logic [D-1:0]  c_IR_RESET = D'(32'h0007_8000);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [D-1:0]     ir_q, ir_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic [3:0] op;
  logic       op_is_nop;
  logic       op_is_store;
  logic       op_is_mem;

  assign op          = ir_q[18:15];
  assign op_is_nop   = (op == c_OP_NOP);
  assign op_is_store = (op == c_OP_STORE);
  assign op_is_mem   = (op == c_OP_LOAD) || op_is_store;

  // State, PC, IR and watchdog registers; async reset returns to a NOP in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= c_IR_RESET;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; the watchdog count defaults to zero so it is cleared
  // on every entry to FETCH or MEM and only advances while a req waits.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = '0;
    retired = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_q == c_WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (op_is_nop) begin
          retired = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = run ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = op_is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op_is_store) begin
            retired = 1'b1;
            pc_d    = pc_q + PC_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == c_WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_WB: begin
        retired = 1'b1;
        pc_d    = pc_q + PC_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // Strobes and requests decode straight from the state register so a reset
  // drops them immediately.
  assign imem_req  = (state_q == S_FETCH);
  assign alu_latch = (state_q == S_EXEC);
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) && op_is_store;
  assign rf_we     = (state_q == S_WB);
  assign busy      = (state_q != S_IDLE) && (state_q != S_ERR);
  assign error     = (state_q == S_ERR);
  assign pc        = pc_q;
  assign ir        = ir_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer (PC_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int D    = 32;
  localparam int PC_W = 4;

  localparam logic [31:0] c_NOP   = 32'h0007_8000;
  localparam logic [31:0] c_ADD   = 32'h0000_0123;
  localparam logic [31:0] c_LOAD  = 32'h0002_0055;
  localparam logic [31:0] c_STORE = 32'h0003_00AA;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic            imem_req;
  logic            imem_ack;
  logic [D-1:0]    imem_rdata;
  logic [PC_W-1:0] pc;
  logic [D-1:0]    ir;
  logic            alu_latch;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;
  logic            rf_we;
  logic            retired;
  logic            busy;
  logic            error;

  int n_checks = 0;
  int n_errors = 0;

  instr_sequencer #(
    .D       (D),
    .PC_W    (PC_W),
    .RESET_PC('0),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .pc        (pc),
    .ir        (ir),
    .alu_latch (alu_latch),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .rf_we     (rf_we),
    .retired   (retired),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the edge that entered FETCH; ack arrives on req cycle waits+1.
  task automatic do_fetch(input logic [31:0] instr, input int waits);
    for (int i = 0; i < waits; i++) begin
      check("fetch_wait_req", {31'd0, imem_req}, 32'd1);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    check("fetch_ack_req", {31'd0, imem_req}, 32'd1);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  initial begin
    rst        = 1'b1;
    run        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    dmem_ack   = 1'b0;
    #12;
    check("rst_pc",    {28'd0, pc}, 32'd0);
    check("rst_ir",    ir, c_NOP);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_ireq",  {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    tick();

    // ADD with ack on the second fetch cycle
    run = 1'b1;
    tick();
    do_fetch(c_ADD, 1);
    check("add_ir", ir, c_ADD);
    check("add_dec_alu", {31'd0, alu_latch}, 32'd0);
    tick();
    check("add_alu", {31'd0, alu_latch}, 32'd1);
    check("add_exec_rfwe", {31'd0, rf_we}, 32'd0);
    run = 1'b0;
    tick();
    check("add_rfwe", {31'd0, rf_we}, 32'd1);
    check("add_ret", {31'd0, retired}, 32'd1);
    check("add_wb_pc", {28'd0, pc}, 32'd0);
    tick();
    check("add_pc", {28'd0, pc}, 32'd1);
    check("add_idle_busy", {31'd0, busy}, 32'd0);
    check("add_idle_ret", {31'd0, retired}, 32'd0);

    // LOAD with dmem_ack on the third MEM cycle, then STORE back to back
    run = 1'b1;
    tick();
    do_fetch(c_LOAD, 0);
    tick();
    check("ld_alu", {31'd0, alu_latch}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld_dreq", {31'd0, dmem_req}, 32'd1);
      check("ld_dwe", {31'd0, dmem_we}, 32'd0);
      check("ld_mem_rfwe", {31'd0, rf_we}, 32'd0);
    end
    dmem_ack = 1'b1;
    #1;
    check("ld_mem_ret", {31'd0, retired}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    check("ld_rfwe", {31'd0, rf_we}, 32'd1);
    check("ld_wb_dreq", {31'd0, dmem_req}, 32'd0);
    check("ld_ret", {31'd0, retired}, 32'd1);
    tick();
    check("ld_pc", {28'd0, pc}, 32'd2);
    do_fetch(c_STORE, 0);
    tick();
    tick();
    check("st_dreq", {31'd0, dmem_req}, 32'd1);
    check("st_dwe", {31'd0, dmem_we}, 32'd1);
    dmem_ack = 1'b1;
    #1;
    check("st_ret", {31'd0, retired}, 32'd1);
    check("st_rfwe", {31'd0, rf_we}, 32'd0);
    run = 1'b0;
    tick();
    dmem_ack = 1'b0;
    check("st_pc", {28'd0, pc}, 32'd3);
    check("st_idle_rfwe", {31'd0, rf_we}, 32'd0);
    check("st_idle_busy", {31'd0, busy}, 32'd0);

    // NOP retires in DECODE
    run = 1'b1;
    tick();
    do_fetch(c_NOP, 0);
    check("nop_ret", {31'd0, retired}, 32'd1);
    check("nop_alu", {31'd0, alu_latch}, 32'd0);
    run = 1'b0;
    tick();
    check("nop_pc", {28'd0, pc}, 32'd4);
    check("nop_alu2", {31'd0, alu_latch}, 32'd0);
    check("nop_rfwe", {31'd0, rf_we}, 32'd0);

    // Ack on the eighth wait cycle is still accepted
    run = 1'b1;
    tick();
    do_fetch(c_ADD, 7);
    check("wd8_err", {31'd0, error}, 32'd0);
    check("wd8_busy", {31'd0, busy}, 32'd1);
    tick();
    run = 1'b0;
    tick();
    tick();
    check("wd8_pc", {28'd0, pc}, 32'd5);

    // Withheld ack traps to ERR after eight req cycles
    run = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_req", {31'd0, imem_req}, 32'd1);
      tick();
    end
    check("to_err", {31'd0, error}, 32'd1);
    check("to_ireq", {31'd0, imem_req}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_pc", {28'd0, pc}, 32'd5);
    check("to_ir", ir, c_ADD);
    imem_ack   = 1'b1;
    imem_rdata = c_LOAD;
    tick();
    tick();
    imem_ack   = 1'b0;
    check("to_sticky", {31'd0, error}, 32'd1);
    check("to_sticky_ir", ir, c_ADD);

    // Recover via reset, then reset again in the middle of MEM
    rst = 1'b1;
    #1;
    rst = 1'b0;
    check("rec_err", {31'd0, error}, 32'd0);
    tick();
    do_fetch(c_NOP, 0);
    tick();
    check("mr_pc1", {28'd0, pc}, 32'd1);
    do_fetch(c_LOAD, 0);
    tick();
    tick();
    check("mr_dreq_pre", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    run = 1'b0;
    #1;
    check("mr_dreq", {31'd0, dmem_req}, 32'd0);
    check("mr_pc", {28'd0, pc}, 32'd0);
    check("mr_ir", ir, c_NOP);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_err", {31'd0, error}, 32'd0);
    check("mr_rfwe", {31'd0, rf_we}, 32'd0);
    rst = 1'b0;
    tick();

    // Sixteen back-to-back NOPs wrap the 4-bit PC from 15 to 0
    run = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      do_fetch(c_NOP, 0);
      if (k == 15) begin
        check("wrap_pc15", {28'd0, pc}, 32'd15);
        run = 1'b0;
      end
      tick();
    end
    check("wrap_pc0", {28'd0, pc}, 32'd0);
    check("wrap_idle", {31'd0, busy}, 32'd0);

    // run dropped during LOAD EXEC: LOAD completes, then IDLE
    run = 1'b1;
    tick();
    do_fetch(c_LOAD, 0);
    tick();
    run = 1'b0;
    tick();
    check("rd_dreq", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("rd_rfwe", {31'd0, rf_we}, 32'd1);
    tick();
    check("rd_pc", {28'd0, pc}, 32'd1);
    check("rd_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rd_ireq", {31'd0, imem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
